memory: RTL and testbench

- Single-port, byte-wide, 256-entry synchronous RAM that serves as the processor's unified program/data store.
- Provides a registered data read port for the datapath and a separate registered instruction-fetch output that feeds the instruction register.
- Shares one address bus for all accesses; sits between the control unit (write/read/ir_en strobes) and the datapath/IR.

---
 rtl/mem_pkg.sv | 9 +
 rtl/mem_array.sv | 23 ++
 rtl/memory.sv | 49 ++++
 tb/tb_memory.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants and types for the 256 x 8 unified program/data RAM.
package mem_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/mem_array.sv
// Storage core: clocked write, combinational read of the addressed word.
// Not reset; contents survive rst_n.
module mem_array
  import mem_pkg::*;
(
  input  logic  power,
  input  logic  write,
  input  addr_t add,
  input  word_t data_in,
  output word_t rd_data
);

  word_t mem [DEPTH];

  always_ff @(posedge power) begin
    if (write) begin
      mem[add] <= data_in;
    end
  end

  assign rd_data = mem[add];

endmodule

// File: rtl/memory.sv
// Unified program/data RAM with registered data read and instruction-fetch ports.
// Build option MEM_WR_FWD_EN: a write coinciding with read/ir_en forwards data_in.
module memory
  import mem_pkg::*;
(
  input  logic  power,
  input  logic  rst_n,
  input  logic  write,
  input  logic  read,
  input  logic  ir_en,
  input  addr_t add,
  input  word_t data_in,
  output word_t data_out,
  output word_t ir_out
);

  word_t rd_word;
  word_t load_word;

  mem_array u_mem_array (
    .power   (power),
    .write   (write),
    .add     (add),
    .data_in (data_in),
    .rd_data (rd_word)
  );

`ifdef MEM_WR_FWD_EN
  assign load_word = write ? data_in : rd_word;
`else
  // Read-first: the array read is taken before this edge's write lands.
  assign load_word = rd_word;
`endif

  always_ff @(posedge power or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
      ir_out   <= '0;
    end else begin
      if (read) begin
        data_out <= load_word;
      end
      if (ir_en) begin
        ir_out <= load_word;
      end
    end
  end

endmodule

// File: tb/tb_memory.sv
// Self-checking bench for memory: directed literal checks plus a random run
// compared every cycle against a behavioural array model.
module tb_memory;
  import mem_pkg::*;

`ifdef MEM_WR_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic  power;
  logic  rst_n;
  logic  write;
  logic  read;
  logic  ir_en;
  addr_t add;
  word_t data_in;
  word_t data_out;
  word_t ir_out;

  int n_cmp = 0;
  int n_bad = 0;

  memory dut (
    .power    (power),
    .rst_n    (rst_n),
    .write    (write),
    .read     (read),
    .ir_en    (ir_en),
    .add      (add),
    .data_in  (data_in),
    .data_out (data_out),
    .ir_out   (ir_out)
  );

  initial begin
    power = 1'b0;
    forever #5 power = ~power;
  end

  // Behavioural model: an array plus a "known" flag per word and per output.
  word_t mdl_mem   [DEPTH];
  bit    mdl_wr    [DEPTH];
  word_t exp_do    = '0;
  word_t exp_ir    = '0;
  bit    exp_do_ok = 1'b1;
  bit    exp_ir_ok = 1'b1;
  bit    chk_en    = 1'b0;

  always @(posedge power or negedge rst_n) begin
    if (!rst_n) begin
      exp_do = '0;
      exp_ir = '0;
      exp_do_ok = 1'b1;
      exp_ir_ok = 1'b1;
    end else begin
      word_t v;
      bit    v_ok;
      if (FWD && write) begin
        v = data_in;
        v_ok = 1'b1;
      end else begin
        v = mdl_mem[add];
        v_ok = mdl_wr[add];
      end
      if (read) begin
        exp_do = v;
        exp_do_ok = v_ok;
      end
      if (ir_en) begin
        exp_ir = v;
        exp_ir_ok = v_ok;
      end
      if (write) begin
        mdl_mem[add] = data_in;
        mdl_wr[add] = 1'b1;
      end
    end
  end

  always @(negedge power) begin
    if (chk_en) begin
      if (exp_do_ok) begin
        n_cmp++;
        if (data_out !== exp_do) begin
          n_bad++;
          $display("FAIL model data_out @%0t: got %0d expected %0d", $time, data_out, exp_do);
        end
      end
      if (exp_ir_ok) begin
        n_cmp++;
        if (ir_out !== exp_ir) begin
          n_bad++;
          $display("FAIL model ir_out @%0t: got %0d expected %0d", $time, ir_out, exp_ir);
        end
      end
    end
  end

  task automatic check(input string name, input word_t act, input word_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input bit w, input bit r, input bit i, input addr_t a, input word_t d);
    write = w;
    read = r;
    ir_en = i;
    add = a;
    data_in = d;
    @(posedge power);
    #1;
    write = 1'b0;
    read = 1'b0;
    ir_en = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) mdl_wr[k] = 1'b0;
    rst_n = 1'b0;
    write = 1'b0;
    read = 1'b0;
    ir_en = 1'b0;
    add = '0;
    data_in = '0;
    repeat (2) @(posedge power);
    #1;
    check("reset data_out", data_out, 8'd0);
    check("reset ir_out", ir_out, 8'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    cyc(1, 0, 0, 8'd11, 8'd38);
    cyc(0, 1, 0, 8'd11, 8'd0);
    check("write/read 11", data_out, 8'd38);
    check("ir_out unchanged", ir_out, 8'd0);

    cyc(1, 0, 0, 8'd11, 8'd45);
    cyc(0, 1, 0, 8'd11, 8'd0);
    check("overwrite 11", data_out, 8'd45);

    cyc(1, 0, 0, 8'd12, 8'd7);
    cyc(0, 1, 1, 8'd11, 8'd0);
    check("read+fetch data_out", data_out, 8'd45);
    check("read+fetch ir_out", ir_out, 8'd45);
    cyc(0, 1, 0, 8'd12, 8'd0);
    check("read 12", data_out, 8'd7);
    check("ir_out held", ir_out, 8'd45);

    cyc(0, 1, 0, 8'd11, 8'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, addr_t'($urandom_range(0, 255)), word_t'($urandom_range(0, 255)));
      check("hold data_out", data_out, 8'd45);
    end
    cyc(0, 0, 0, 8'd11, 8'd37);
    cyc(0, 1, 0, 8'd11, 8'd0);
    check("idle no write", data_out, 8'd45);

    // Asynchronous reset mid-cycle with read asserted.
    read = 1'b1;
    add = 8'd12;
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst data_out", data_out, 8'd0);
    check("async rst ir_out", ir_out, 8'd0);
    @(posedge power);
    #1;
    check("rst held data_out", data_out, 8'd0);
    read = 1'b0;
    rst_n = 1'b1;
    cyc(0, 1, 0, 8'd11, 8'd0);
    check("array survives reset", data_out, 8'd45);

    cyc(1, 0, 0, 8'd20, 8'd5);
    cyc(1, 1, 1, 8'd20, 8'd9);
    check("rdw data_out", data_out, FWD ? 8'd9 : 8'd5);
    check("rdw ir_out", ir_out, FWD ? 8'd9 : 8'd5);
    cyc(0, 1, 0, 8'd20, 8'd0);
    check("after rdw", data_out, 8'd9);

    for (int k = 0; k < 400; k++) begin
      cyc(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
          addr_t'($urandom_range(0, 15)), word_t'($urandom_range(0, 255)));
    end
    @(negedge power);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
